round_timer: RTL



---
 rtl/game_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/round_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and state encoding for the mole game blocks.
// Used by the start controller, round timer and display.
package game_pkg;

    localparam int ROUND_W        = 3;
    localparam int SEC_W          = 4;
    localparam int DEF_ROUNDS     = 5;
    localparam int DEF_ROUND_SECS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle wrap pulse every CLK_DIV enabled cycles.
// Count is held while cnt_en is low and cleared by clr.
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = cnt_en && (cnt_q == LAST);

    // Prescaler count: clear, hold, or advance with wrap at LAST
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (cnt_en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/round_timer.sv
// Per-round second countdown and round decrement for the mole game.
// Optional `warn` output when TIMER_WARN_EN is defined.
module round_timer
    import game_pkg::*;
#(
    parameter int CLK_DIV    = 50_000_000,
    parameter int ROUNDS     = DEF_ROUNDS,
    parameter int ROUND_SECS = DEF_ROUND_SECS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               ini,
    output logic [ROUND_W-1:0] round,
    output logic [SEC_W-1:0]   sec_left,
    output logic               tick,
    output logic               round_done,
    output logic               game_over,
`ifdef TIMER_WARN_EN
    output logic               warn,
`endif
    output logic               running
);

    if (ROUNDS < 1 || ROUNDS > 7) begin : g_bad_rounds
        $error("round_timer: ROUNDS must be 1..7");
    end
    if (ROUND_SECS < 1 || ROUND_SECS > 15) begin : g_bad_secs
        $error("round_timer: ROUND_SECS must be 1..15");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("round_timer: CLK_DIV must be >= 2");
    end

    localparam logic [ROUND_W-1:0] ROUND_RLD = ROUND_W'(ROUNDS);
    localparam logic [SEC_W-1:0]   SEC_RLD   = SEC_W'(ROUND_SECS);

    timer_state_t       state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               pre_tick;
    logic               pre_clr;
    logic               pre_en;

    // Prescaler restarts on ini and while idle; advances only in RUN
    assign pre_clr = ini || (state_q == IDLE);
    assign pre_en  = (state_q == RUN) && !ini;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_pre (
        .clk    (clk),
        .rst    (rst),
        .clr    (pre_clr),
        .cnt_en (pre_en),
        .tick   (pre_tick)
    );

    // Next state, counter updates and pulses; ini overrides everything
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (ini) begin
            state_d = IDLE;
            round_d = ROUND_RLD;
            sec_d   = SEC_RLD;
        end else begin
            case (state_q)
                IDLE: begin
                    round_d = ROUND_RLD;
                    sec_d   = SEC_RLD;
                    if (en) state_d = RUN;
                end
                RUN: begin
                    if (!en) state_d = PAUSE;
                    if (pre_tick) begin
                        tick_d = 1'b1;
                        if (sec_q > SEC_W'(1)) begin
                            sec_d = sec_q - 1'b1;
                        end else begin
                            round_d = round_q - 1'b1;
                            done_d  = 1'b1;
                            if (round_q == ROUND_W'(1)) begin
                                sec_d   = '0;
                                state_d = OVER;
                            end else begin
                                sec_d = SEC_RLD;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (en) state_d = RUN;
                end
                OVER: begin
                    round_d = '0;
                    sec_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= ROUND_RLD;
            sec_q   <= SEC_RLD;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

`ifdef TIMER_WARN_EN
    // Last-seconds blink flag, aligned with the sec_left update
    always_ff @(posedge clk) begin
        if (rst) begin
            warn <= 1'b0;
        end else begin
            warn <= (state_d == RUN) && (sec_d <= SEC_W'(3));
        end
    end
`endif

    assign round      = round_q;
    assign sec_left   = sec_q;
    assign tick       = tick_q;
    assign round_done = done_q;
    assign game_over  = (state_q == OVER);
    assign running    = (state_q == RUN);

endmodule
